// File: rtl/toggle_activity_monitor.sv
// Switching-activity monitor: counts input/output toggles and output-high
// samples over a window of valid samples, then reports them via valid/ready.
module toggle_activity_monitor #(
  parameter int IN_W  = 4,
  parameter int CNT_W = 16,
  parameter int WIN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIN_W-1:0] win_len,
  input  logic             smp_valid,
  input  logic [IN_W-1:0]  smp_in,
  input  logic             smp_out,
  output logic             busy,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [CNT_W-1:0] rpt_in_toggles,
  output logic [CNT_W-1:0] rpt_out_toggles,
  output logic [CNT_W-1:0] rpt_ones,
  output logic             rpt_ovf
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_COUNT,
    S_REPORT
  } state_e;

  state_e           state_q;
  logic             busy_q;
  logic             rpt_valid_q;
  logic [WIN_W-1:0] win_q;
  logic [WIN_W-1:0] rem_q;
  logic [IN_W-1:0]  prev_in_q;
  logic             prev_out_q;
  logic [CNT_W-1:0] in_tog_q;
  logic [CNT_W-1:0] out_tog_q;
  logic [CNT_W-1:0] ones_q;
  logic             ovf_q;

  logic [CNT_W:0]   pop;
  logic [CNT_W:0]   in_sum;
  logic [CNT_W:0]   out_sum;
  logic [CNT_W:0]   ones_sum;
  logic [CNT_W-1:0] in_tog_d;
  logic [CNT_W-1:0] out_tog_d;
  logic [CNT_W-1:0] ones_d;
  logic             cnt_ovf_d;
  logic             ones_ovf_d;
  logic [IN_W-1:0]  diff;

  function automatic logic [CNT_W-1:0] sat(input logic [CNT_W:0] s);
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  always_comb begin
    diff = smp_in ^ prev_in_q;
    pop  = '0;
    for (int i = 0; i < IN_W; i++) begin
      pop = pop + (CNT_W+1)'(diff[i]);
    end
    in_sum   = {1'b0, in_tog_q} + pop;
    out_sum  = {1'b0, out_tog_q} + (CNT_W+1)'(smp_out ^ prev_out_q);
    ones_sum = {1'b0, ones_q} + (CNT_W+1)'(smp_out);
    in_tog_d   = sat(in_sum);
    out_tog_d  = sat(out_sum);
    ones_d     = sat(ones_sum);
    ones_ovf_d = ones_sum[CNT_W];
    cnt_ovf_d  = in_sum[CNT_W] | out_sum[CNT_W] | ones_sum[CNT_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      rpt_valid_q <= 1'b0;
      win_q       <= '0;
      rem_q       <= '0;
      prev_in_q   <= '0;
      prev_out_q  <= 1'b0;
      in_tog_q    <= '0;
      out_tog_q   <= '0;
      ones_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start && (win_len != '0)) begin
            win_q     <= win_len;
            in_tog_q  <= '0;
            out_tog_q <= '0;
            ones_q    <= '0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= S_PRIME;
          end
        end
        S_PRIME: begin
          // First sample only seeds the history; no toggles yet.
          if (smp_valid) begin
            prev_in_q  <= smp_in;
            prev_out_q <= smp_out;
            ones_q     <= ones_d;
            ovf_q      <= ovf_q | ones_ovf_d;
            rem_q      <= win_q - 1'b1;
            if (win_q == WIN_W'(1)) begin
              rpt_valid_q <= 1'b1;
              state_q     <= S_REPORT;
            end else begin
              state_q <= S_COUNT;
            end
          end
        end
        S_COUNT: begin
          if (smp_valid) begin
            prev_in_q  <= smp_in;
            prev_out_q <= smp_out;
            in_tog_q   <= in_tog_d;
            out_tog_q  <= out_tog_d;
            ones_q     <= ones_d;
            ovf_q      <= ovf_q | cnt_ovf_d;
            rem_q      <= rem_q - 1'b1;
            if (rem_q == WIN_W'(1)) begin
              rpt_valid_q <= 1'b1;
              state_q     <= S_REPORT;
            end
          end
        end
        S_REPORT: begin
          if (rpt_ready) begin
            rpt_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          busy_q      <= 1'b0;
          rpt_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy            = busy_q;
  assign rpt_valid       = rpt_valid_q;
  assign rpt_in_toggles  = in_tog_q;
  assign rpt_out_toggles = out_tog_q;
  assign rpt_ones        = ones_q;
  assign rpt_ovf         = ovf_q;

endmodule

// File: tb/tb_toggle_activity_monitor.sv
// Bench for toggle_activity_monitor: directed windows plus random windows
// checked against a queue-based activity model.
module tb_toggle_activity_monitor;

  localparam int IN_W  = 4;
  localparam int CNT_W = 4;
  localparam int WIN_W = 16;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIN_W-1:0] win_len;
  logic             smp_valid;
  logic [IN_W-1:0]  smp_in;
  logic             smp_out;
  logic             busy;
  logic             rpt_valid;
  logic             rpt_ready;
  logic [CNT_W-1:0] rpt_in_toggles;
  logic [CNT_W-1:0] rpt_out_toggles;
  logic [CNT_W-1:0] rpt_ones;
  logic             rpt_ovf;

  int n_chk;
  int n_fail;
  int exp_it, exp_ot, exp_on, exp_ovf;

  logic [IN_W-1:0] q_in[$];
  logic            q_out[$];
  int              gaps_q[$];

  toggle_activity_monitor #(
    .IN_W (IN_W),
    .CNT_W(CNT_W),
    .WIN_W(WIN_W)
  ) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .win_len        (win_len),
    .smp_valid      (smp_valid),
    .smp_in         (smp_in),
    .smp_out        (smp_out),
    .busy           (busy),
    .rpt_valid      (rpt_valid),
    .rpt_ready      (rpt_ready),
    .rpt_in_toggles (rpt_in_toggles),
    .rpt_out_toggles(rpt_out_toggles),
    .rpt_ones       (rpt_ones),
    .rpt_ovf        (rpt_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compute_exp();
    int it, ot, on;
    it = 0;
    ot = 0;
    on = 0;
    for (int i = 0; i < q_in.size(); i++) begin
      on += int'(q_out[i]);
      if (i > 0) begin
        it += $countones(q_in[i] ^ q_in[i-1]);
        ot += (q_out[i] != q_out[i-1]) ? 1 : 0;
      end
    end
    exp_ovf = (it > MAXC || ot > MAXC || on > MAXC) ? 1 : 0;
    exp_it  = (it > MAXC) ? MAXC : it;
    exp_ot  = (ot > MAXC) ? MAXC : ot;
    exp_on  = (on > MAXC) ? MAXC : on;
  endtask

  task automatic check_rpt(input string tag);
    check({tag, "_it"},  32'(rpt_in_toggles),  32'(exp_it));
    check({tag, "_ot"},  32'(rpt_out_toggles), 32'(exp_ot));
    check({tag, "_on"},  32'(rpt_ones),        32'(exp_on));
    check({tag, "_ovf"}, 32'(rpt_ovf),         32'(exp_ovf));
  endtask

  task automatic run_window(input int gap_max, input int stall,
                            input bit poke_start);
    int n, g;
    compute_exp();
    n = q_in.size();
    @(negedge clk);
    start   = 1'b1;
    win_len = WIN_W'(n);
    @(negedge clk);
    start = 1'b0;
    check("busy_start", 32'(busy), 1);
    for (int i = 0; i < n; i++) begin
      g = (gaps_q.size() > i) ? gaps_q[i] : int'($urandom_range(gap_max, 0));
      repeat (g) begin
        smp_valid = 1'b0;
        smp_in    = IN_W'($urandom);
        smp_out   = 1'($urandom);
        @(negedge clk);
      end
      smp_valid = 1'b1;
      smp_in    = q_in[i];
      smp_out   = q_out[i];
      @(negedge clk);
      smp_valid = 1'b0;
      if (i < n - 1) check("no_early_valid", 32'(rpt_valid), 0);
    end
    check("rpt_valid", 32'(rpt_valid), 1);
    check_rpt("rpt");
    for (int s = 0; s < stall; s++) begin
      smp_valid = 1'b1;
      smp_in    = IN_W'($urandom);
      smp_out   = 1'($urandom);
      if (poke_start && s == 0) begin
        start   = 1'b1;
        win_len = 3;
      end
      @(negedge clk);
      start = 1'b0;
      check("stall_valid", 32'(rpt_valid), 1);
      check("stall_busy", 32'(busy), 1);
      check_rpt("stall");
    end
    smp_valid = 1'b0;
    rpt_ready = 1'b1;
    @(negedge clk);
    rpt_ready = 1'b0;
    check("post_valid", 32'(rpt_valid), 0);
    check("post_busy", 32'(busy), 0);
    check_rpt("retain");
    gaps_q.delete();
  endtask

  task automatic push(input logic [IN_W-1:0] i, input logic o);
    q_in.push_back(i);
    q_out.push_back(o);
  endtask

  task automatic clear_q();
    q_in.delete();
    q_out.delete();
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    win_len   = '0;
    smp_valid = 1'b0;
    smp_in    = '0;
    smp_out   = 1'b0;
    rpt_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(rpt_valid), 0);
    check("rst_it", 32'(rpt_in_toggles), 0);
    check("rst_ovf", 32'(rpt_ovf), 0);
    rst_n = 1'b1;
    @(negedge clk);

    clear_q();
    push(4'b0000, 0); push(4'b0001, 1);
    push(4'b0011, 1); push(4'b0011, 0);
    run_window(0, 0, 0);
    check("t1_it_const", 32'(rpt_in_toggles), 2);

    clear_q();
    push(4'b1111, 1);
    run_window(2, 1, 0);

    clear_q();
    for (int i = 0; i < 20; i++) push(4'b1010, 1'(i % 2));
    run_window(0, 0, 0);
    check("t3_ot_sat", 32'(rpt_out_toggles), 15);
    check("t3_ovf", 32'(rpt_ovf), 1);

    clear_q();
    push(4'b0110, 1); push(4'b1001, 0); push(4'b1000, 1);
    gaps_q = '{0, 2, 4};
    run_window(0, 5, 1);
    repeat (3) @(negedge clk);
    check("t4_idle_busy", 32'(busy), 0);

    start   = 1'b1;
    win_len = 0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin
      smp_valid = 1'b1;
      @(negedge clk);
      check("t5_len0_busy", 32'(busy), 0);
      check("t5_len0_valid", 32'(rpt_valid), 0);
    end
    smp_valid = 1'b0;
    start     = 1'b1;
    win_len   = 8;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      smp_valid = 1'b1;
      smp_in    = IN_W'(i * 5);
      smp_out   = 1'b1;
      @(negedge clk);
    end
    smp_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("t5_rst_busy", 32'(busy), 0);
    check("t5_rst_valid", 32'(rpt_valid), 0);
    check("t5_rst_on", 32'(rpt_ones), 0);
    check("t5_rst_it", 32'(rpt_in_toggles), 0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_q();
    push(4'b0001, 0); push(4'b0001, 1); push(4'b0000, 1);
    run_window(1, 0, 0);

    clear_q();
    for (int i = 0; i < 6; i++) push(IN_W'($urandom), 1'($urandom));
    run_window(0, 0, 0);
    clear_q();
    push(4'b0101, 1); push(4'b1010, 0);
    run_window(0, 0, 0);
    check("t6_it", 32'(rpt_in_toggles), 4);

    for (int w = 0; w < 12; w++) begin
      int len;
      len = int'($urandom_range(30, 1));
      clear_q();
      for (int i = 0; i < len; i++) push(IN_W'($urandom), 1'($urandom));
      run_window(2, int'($urandom_range(3, 0)), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/toggle_activity_monitor.md
Name: toggle_activity_monitor

Overview:
Downstream measurement stage for the power-experiment sub-circuits. It consumes each applied input vector together with the sub-circuit's 1-bit output. Over a programmable window of valid samples it counts:
- bit toggles on the input vector,
- toggles on the output,
- cycles the output spent at 1.
It then reports the three counts through a valid/ready handshake to the experiment controller, which compares switching activity before and after rewrite.

Parameters:
IN_W, 4, width of sampled input vector (sub-circuit primary inputs)
CNT_W, 16, width of each activity counter (saturating)
WIN_W, 16, width of window-length field

Ports:
clk  input  1  sole clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begins a window when IDLE
win_len  input  WIN_W  number of valid samples in window; latched on accepted start
smp_valid  input  1  current smp_in/smp_out pair is a sample
smp_in  input  IN_W  input vector applied to sub-circuit
smp_out  input  1  sub-circuit output for that vector
busy  output  1  high in PRIME, COUNT, REPORT
rpt_valid  output  1  report available
rpt_ready  input  1  consumer accepts report
rpt_in_toggles  output  CNT_W  sum of popcount(smp_in XOR previous smp_in)
rpt_out_toggles  output  CNT_W  count of smp_out changes between consecutive samples
rpt_ones  output  CNT_W  count of samples with smp_out=1
rpt_ovf  output  1  any counter saturated during window

Behaviour:
- Reset (async assert, sync release): state IDLE. busy=0, rpt_valid=0, all rpt_* counters 0, rpt_ovf=0. Prev-sample registers and latched window length are cleared to 0.
- FSM states: IDLE, PRIME, COUNT, REPORT.
- IDLE:
  - start=1 and win_len!=0: latch win_len, clear counters and ovf, go PRIME.
  - start=1 and win_len=0: ignored, stay IDLE.
  - Samples in IDLE are ignored.
- PRIME: first sample with smp_valid=1:
  - store smp_in/smp_out as prev;
  - rpt_ones += smp_out;
  - remaining = win_len-1;
  - if remaining=0, go REPORT, else COUNT.
  - No toggles are counted on the first sample.
- COUNT: each sample with smp_valid=1:
  - in_toggles += popcount(smp_in ^ prev_in);
  - out_toggles += (smp_out ^ prev_out);
  - ones += smp_out;
  - prev <= sample; remaining -= 1;
  - on the sample that takes remaining to 0, go REPORT.
  - smp_valid=0 cycles leave all state unchanged; gaps are not counted.
- Arithmetic: each counter adds with saturation at 2^CNT_W-1. If a true sum would exceed the maximum, the counter holds the maximum and rpt_ovf sets sticky for the window. popcount of an IN_W-bit XOR is added in one cycle.
- REPORT:
  - rpt_valid=1 from the cycle after the final sample is accepted (latency 1).
  - rpt_* values are stable while rpt_valid=1 and rpt_ready=0.
  - On rpt_valid&rpt_ready: go IDLE and deassert rpt_valid next cycle. rpt_* retain their values until the next accepted start clears them.
  - Samples in REPORT are ignored.
- start is ignored in PRIME, COUNT and REPORT. There is no restart mid-window.
- Reset asserted in any state: immediate return to the reset values above. A partial window is discarded, with no report.
- busy = (state != IDLE).

Test Plan:
1. start, win_len=4. Samples (smp_in, smp_out): (0000,0), (0001,1), (0011,1), (0011,0).
   -> rpt_valid one cycle after 4th sample; in_toggles=2, out_toggles=2, ones=2, ovf=0.
2. win_len=1, single sample (1111,1).
   -> straight PRIME→REPORT; in_toggles=0, out_toggles=0, ones=1.
3. CNT_W=4, win_len=20, smp_out alternating 0,1,…, smp_in constant.
   -> out_toggles=15 (saturated, true 19), ones=10, rpt_ovf=1.
4. win_len=3 with smp_valid gaps (valid on cycles 1, 4, 9), rpt_ready held low 5 cycles after rpt_valid, start pulsed during REPORT.
   -> only 3 samples counted; rpt_* stable while stalled; start ignored; IDLE after handshake.
5. start with win_len=0.
   -> busy stays 0, no report. Then rst_n low mid-COUNT (win_len=8, 3 samples in).
   -> busy=0, rpt_valid=0, counters 0 immediately; new window after release counts from zero.
6. Back-to-back windows: report accepted, start on the next cycle with win_len=2, samples (0101,1), (1010,0).
   -> second report in_toggles=4, out_toggles=1, ones=1, ovf=0. Counters do not carry over from the first window.
